pwm_carrier_gen: RTL and testbench

//  Center-aligned (triangle-carrier) PWM generator feeding the Sin input of single_leg_switch.

---
 rtl/pwm_carrier_gen.sv | 92 +++++++++
 tb/tb_pwm_carrier_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_carrier_gen.sv
// Centre-aligned triangle-carrier PWM with a double-buffered duty command committed at carrier zero.
// Define PWM_DOUBLE_UPDATE_EN to also commit at the carrier peak (two updates per period).
module pwm_carrier_gen #(
    parameter int CNT_W  = 16,
    parameter int PERIOD = 1250
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic [CNT_W-1:0] carrier,
    output logic             zero_pulse,
    output logic             peak_pulse,
    output logic             duty_err
);
    localparam logic [CNT_W-1:0] PER   = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] PER_M = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt, active_duty, stage;
    logic             dir_down, pending;
    logic             hi, at_update, commit, accept, clamp;

    always_comb begin
        // Up phase uses <, down phase <=, giving 2*D high clocks centred on zero.
        hi = dir_down ? (cnt <= active_duty) : (cnt < active_duty);
`ifdef PWM_DOUBLE_UPDATE_EN
        at_update = (cnt == '0) || (cnt == PER);
`else
        at_update = (cnt == '0);
`endif
        commit = enable && pending && at_update;
        accept = duty_valid && !pending;
        clamp  = stage > PER;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (!enable) begin
            cnt      <= '0;
            dir_down <= 1'b0;
        end else if (!dir_down) begin
            if (cnt == PER_M) begin
                cnt      <= PER;
                dir_down <= 1'b1;
            end else begin
                cnt <= cnt + ONE;
            end
        end else begin
            if (cnt == ONE) begin
                cnt      <= '0;
                dir_down <= 1'b0;
            end else begin
                cnt <= cnt - ONE;
            end
        end
    end

    // Accept and commit are mutually exclusive: one needs pending low, the other high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            active_duty <= '0;
            stage       <= '0;
            pending     <= 1'b0;
            duty_err    <= 1'b0;
        end else begin
            duty_err <= commit && clamp;
            if (commit) begin
                active_duty <= clamp ? PER : stage;
                pending     <= 1'b0;
            end else if (accept) begin
                stage   <= duty;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pwm_out <= 1'b0;
        else     pwm_out <= enable && hi;
    end

    assign duty_ready = !pending;
    assign carrier    = cnt;
    assign zero_pulse = enable && (cnt == '0);
    assign peak_pulse = enable && (cnt == PER);
endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Scoreboard bench for pwm_carrier_gen: a phase-index model predicts every cycle's outputs.
module tb_pwm_carrier_gen;
    localparam int W = 8;
    localparam int P = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         enable;
    logic [W-1:0] duty;
    logic         duty_valid;
    logic         duty_ready, pwm_out, zero_pulse, peak_pulse, duty_err;
    logic [W-1:0] carrier;

    pwm_carrier_gen #(.CNT_W(W), .PERIOD(P)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .duty(duty), .duty_valid(duty_valid),
        .duty_ready(duty_ready), .pwm_out(pwm_out), .carrier(carrier),
        .zero_pulse(zero_pulse), .peak_pulse(peak_pulse), .duty_err(duty_err)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         pwm, rdy, zero, peak, err;
    } obs_t;

    obs_t sb[$];
    int   send_q[$];
    int   checks = 0, failures = 0;
    int   hi_acc, err_acc;

    // Model: phase index t in 0..2P-1; t<P is the up phase with cnt=t, else cnt=2P-t.
    int   m_t, m_act, m_stage;
    bit   m_pend, m_pwm, m_err, m_commit;

    function automatic int mcnt();
        return (m_t < P) ? m_t : 2 * P - m_t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_act = 0; m_stage = 0;
        m_pend = 0; m_pwm = 0; m_err = 0; m_commit = 0;
    endtask

    task automatic step();
        int   c;
        bit   up, hi, acc, at_pt;
        obs_t e, o;
        duty_valid = send_q.size() > 0;
        duty = '0;
        if (duty_valid) duty = W'(send_q[0]);
        c  = mcnt();
        up = m_t < P;
        hi = up ? (c < m_act) : (c <= m_act);
        at_pt = (c == 0);
`ifdef PWM_DOUBLE_UPDATE_EN
        at_pt = at_pt || (c == P);
`endif
        m_commit = enable && m_pend && at_pt;
        acc      = duty_valid && !m_pend;
        m_pwm    = enable && hi;
        m_err    = m_commit && (m_stage > P);
        if (m_commit) begin
            m_act  = (m_stage > P) ? P : m_stage;
            m_pend = 0;
        end
        if (acc) begin
            m_stage = send_q.pop_front();
            m_pend  = 1;
        end
        m_t = enable ? (m_t + 1) % (2 * P) : 0;
        e.cnt  = W'(mcnt());
        e.pwm  = m_pwm;
        e.rdy  = !m_pend;
        e.zero = enable && (mcnt() == 0);
        e.peak = enable && (mcnt() == P);
        e.err  = m_err;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        o = '{carrier, pwm_out, duty_ready, zero_pulse, peak_pulse, duty_err};
        e = sb.pop_front();
        chk("carrier", 32'(o.cnt), 32'(e.cnt));
        chk("pwm_out", 32'(o.pwm), 32'(e.pwm));
        chk("duty_ready", 32'(o.rdy), 32'(e.rdy));
        chk("zero_pulse", 32'(o.zero), 32'(e.zero));
        chk("peak_pulse", 32'(o.peak), 32'(e.peak));
        chk("duty_err", 32'(o.err), 32'(e.err));
        if (o.pwm === 1'b1) hi_acc++;
        if (o.err === 1'b1) err_acc++;
    endtask

    task automatic wait_commit(input string tag);
        int n = 0;
        while (!m_commit && n < 64) begin
            step();
            n++;
        end
        if (!m_commit) chk({tag, "_commit_timeout"}, 0, 1);
    endtask

    task automatic run_period(input string tag, input int exp_hi);
        hi_acc = 0;
        repeat (2 * P) step();
        chk(tag, 32'(hi_acc), 32'(exp_hi));
    endtask

    initial begin
        RST = 1'b1; enable = 1'b0; duty = '0; duty_valid = 1'b0;
        model_reset();
        #12;
        chk("rst_carrier", 32'(carrier), 0);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_ready", 32'(duty_ready), 1);
        chk("rst_err", 32'(duty_err), 0);
        chk("rst_zero", 32'(zero_pulse), 0);
        @(negedge CLK);
        RST = 1'b0;
        enable = 1'b1;

        // duty=3: 6 high clocks per period
        send_q.push_back(3);
        wait_commit("d3");
        run_period("highs_d3", 6);

        // duty extremes
        err_acc = 0;
        send_q.push_back(0);
        wait_commit("d0");
        run_period("highs_d0", 0);
        send_q.push_back(8);
        wait_commit("d8");
        run_period("highs_d8", 16);
        chk("err_extremes", 32'(err_acc), 0);

        // clamp: 12 -> 8 with a single duty_err pulse
        err_acc = 0;
        send_q.push_back(12);
        wait_commit("d12");
        chk("clamp_err_now", 32'(duty_err), 1);
        run_period("highs_clamp", 16);
        chk("clamp_err_count", 32'(err_acc), 1);

        // back-to-back writes mid-period
        repeat (3) step();
        send_q.push_back(2);
        send_q.push_back(5);
        step();
        chk("b2b_ready_low", 32'(duty_ready), 0);
        wait_commit("d2");
        run_period("highs_d2", 4);
        chk("d5_committed", 32'(m_commit), 1);
        run_period("highs_d5", 10);

        // disable mid-period with a pending write
        send_q.push_back(7);
        step();
        while (mcnt() != 5) step();
        enable = 1'b0;
        step();
        chk("dis_carrier", 32'(carrier), 0);
        chk("dis_pwm", 32'(pwm_out), 0);
        repeat (3) step();
        chk("dis_pending", 32'(duty_ready), 0);
        enable = 1'b1;
        step();
        chk("reen_commit", 32'(duty_ready), 1);
        run_period("highs_d7", 14);

        // async reset mid-period with pending write
        send_q.push_back(6);
        repeat (4) step();
        #2 RST = 1'b1;
        #1;
        chk("arst_carrier", 32'(carrier), 0);
        chk("arst_pwm", 32'(pwm_out), 0);
        chk("arst_ready", 32'(duty_ready), 1);
        chk("arst_err", 32'(duty_err), 0);
        chk("arst_zero", 32'(zero_pulse), 1);
        model_reset();
        send_q.delete();
        #1 RST = 1'b0;
        run_period("highs_after_rst", 0);

        // update point: peak in the double-update build, zero otherwise
        repeat (2) step();
        send_q.push_back(4);
        wait_commit("d4");
`ifdef PWM_DOUBLE_UPDATE_EN
        chk("update_point", 32'(carrier), P - 1);
`else
        chk("update_point", 32'(carrier), 1);
`endif
        run_period("highs_d4", 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
